// File: rtl/pwm_multi_pkg.sv
// -----------------------------------------------------------------------------
// pwm_multi_pkg
//   Shared definitions for the multi-channel PWM generator.
//   - Default parameter values for pwm_multi / pwm_chan.
//   - clamp_u32 : duty clamp helper (values zero-extended to 32 bits).
//   - duty_lsb  : LSB position of channel ch inside the packed duty bus.
// -----------------------------------------------------------------------------
package pwm_multi_pkg;

    localparam int unsigned DEF_CH           = 4;
    localparam int unsigned DEF_CW           = 16;
    localparam int unsigned DEF_PERIOD_RST   = 32'h0000_FFFF;
    localparam int unsigned DEF_MIN_DUTY     = 256;
    localparam int unsigned DEF_MAX_DUTY     = 65535;
    localparam int unsigned DEF_WDOG_PERIODS = 50;

    // Clamp v into [lo, hi]; lo takes priority if the bounds are inverted.
    function automatic logic [31:0] clamp_u32(input logic [31:0] v,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        logic [31:0] r;
        r = v;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // Channel ch occupies bits [ch*cw +: cw] of the packed duty bus.
    function automatic int unsigned duty_lsb(input int unsigned ch,
                                             input int unsigned cw);
        return ch * cw;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// -----------------------------------------------------------------------------
// pwm_chan
//   One PWM channel: duty shadow register, active duty register, pending flag,
//   clamp and registered compare against the shared period counter.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   i_arm         1 = outputs enabled and duty clamped, 0 = effective duty 0
//   i_force_off   forces the effective duty to 0 (watchdog)
//   i_wrap        high on the cycle the shared counter equals the period
//   i_cnt         shared period counter
//   i_duty        new duty value
//   i_duty_we     single-cycle write strobe for i_duty
//   o_pend        shadow holds a value not yet transferred
//   o_pwm         registered PWM output
// -----------------------------------------------------------------------------
module pwm_chan
    import pwm_multi_pkg::*;
#(
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned MIN_DUTY = DEF_MIN_DUTY,
    parameter int unsigned MAX_DUTY = DEF_MAX_DUTY
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_arm,
    input  logic          i_force_off,
    input  logic          i_wrap,
    input  logic [CW-1:0] i_cnt,
    input  logic [CW-1:0] i_duty,
    input  logic          i_duty_we,
    output logic          o_pend,
    output logic          o_pwm
);

    logic [CW-1:0] r_duty_sh;
    logic [CW-1:0] r_duty_act;
    logic          r_pend;
    logic          r_pwm;
    logic [CW-1:0] w_eff;

    // Shadow: last write before the wrap wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_sh <= '0;
        end else if (i_duty_we) begin
            r_duty_sh <= i_duty;
        end
    end

    // A strobe on the wrap cycle itself wins over the clear, so that value
    // stays pending for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (i_duty_we) begin
            r_pend <= 1'b1;
        end else if (i_wrap) begin
            r_pend <= 1'b0;
        end
    end

    // Active duty only changes at the period boundary: no runt pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_act <= '0;
        end else if (i_wrap && r_pend) begin
            r_duty_act <= r_duty_sh;
        end
    end

    // Arm and force-off act immediately, not at the boundary.
    always_comb begin
        w_eff = '0;
        if (i_arm && !i_force_off) begin
            w_eff = CW'(clamp_u32(32'(r_duty_act), 32'(MIN_DUTY), 32'(MAX_DUTY)));
        end
    end

    // eff > period gives a constant-high output since cnt never reaches eff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (i_cnt < w_eff);
        end
    end

    assign o_pend = r_pend;
    assign o_pwm  = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//   Multi-channel PWM generator with one shared period counter. Period and
//   per-channel duty are double-buffered and transfer at the period wrap.
//   Optional command watchdog compiled in with macro PWM_MULTI_WATCHDOG_EN.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   i_arm           level; 1 enables outputs and duty clamping
//   i_period_in     new period value (period length = value+1, 0 stored as 1)
//   i_period_we     single-cycle write strobe for i_period_in
//   i_duty_in       packed duties, channel i in bits [i*CW +: CW]
//   i_duty_we       per-channel duty write strobes
//   o_pwm_out       registered PWM outputs
//   o_period_tick   high on the wrap cycle (cnt == active period)
//   o_busy          any shadow write pending
//   o_wdog_fault    watchdog tripped (0 when the watchdog is compiled out)
// -----------------------------------------------------------------------------
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int unsigned CH           = DEF_CH,
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned PERIOD_RST   = DEF_PERIOD_RST,
    parameter int unsigned MIN_DUTY     = DEF_MIN_DUTY,
    parameter int unsigned MAX_DUTY     = DEF_MAX_DUTY,
    parameter int unsigned WDOG_PERIODS = DEF_WDOG_PERIODS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_arm,
    input  logic [CW-1:0]    i_period_in,
    input  logic             i_period_we,
    input  logic [CH*CW-1:0] i_duty_in,
    input  logic [CH-1:0]    i_duty_we,
    output logic [CH-1:0]    o_pwm_out,
    output logic             o_period_tick,
    output logic             o_busy,
    output logic             o_wdog_fault
);

    localparam logic [CW-1:0] PERIOD_RST_V = CW'(PERIOD_RST);

    // Elaboration-time parameter sanity checks.
    if (WDOG_PERIODS == 0) begin : g_bad_wdog
        $error("pwm_multi: WDOG_PERIODS must be at least 1");
    end
    if (MIN_DUTY > MAX_DUTY) begin : g_bad_clamp
        $error("pwm_multi: MIN_DUTY must not exceed MAX_DUTY");
    end

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_period_act;
    logic [CW-1:0] r_period_sh;
    logic          r_pend_p;
    logic          w_wrap;
    logic          w_force_off;
    logic [CH-1:0] w_pend;

    assign w_wrap = (r_cnt == r_period_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A zero period would never let the outputs toggle; store it as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_sh <= PERIOD_RST_V;
        end else if (i_period_we) begin
            r_period_sh <= (i_period_in == '0) ? CW'(1) : i_period_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_p <= 1'b0;
        end else if (i_period_we) begin
            r_pend_p <= 1'b1;
        end else if (w_wrap) begin
            r_pend_p <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_act <= PERIOD_RST_V;
        end else if (w_wrap && r_pend_p) begin
            r_period_act <= r_period_sh;
        end
    end

`ifdef PWM_MULTI_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_PERIODS + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wdog_fault;
    logic            r_wd_mask;
    logic            w_duty_any;
    logic            w_wd_trip;

    assign w_duty_any = |i_duty_we;
    assign w_wd_trip  = !w_duty_any && w_wrap &&
                        (r_wd_cnt == WD_W'(WDOG_PERIODS - 1));

    // Whole periods since the last duty write, saturating at the trip value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt     <= '0;
            r_wdog_fault <= 1'b0;
        end else if (w_duty_any) begin
            r_wd_cnt     <= '0;
            r_wdog_fault <= 1'b0;
        end else if (w_wrap) begin
            if (r_wd_cnt != WD_W'(WDOG_PERIODS)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_trip) begin
                r_wdog_fault <= 1'b1;
            end
        end
    end

    // Outputs stay off until the first wrap after the fault has cleared, so a
    // recovering channel always restarts on a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_mask <= 1'b0;
        end else if (w_wd_trip) begin
            r_wd_mask <= 1'b1;
        end else if (w_wrap && !r_wdog_fault) begin
            r_wd_mask <= 1'b0;
        end
    end

    assign w_force_off  = r_wd_mask;
    assign o_wdog_fault = r_wdog_fault;
`else
    assign w_force_off  = 1'b0;
    assign o_wdog_fault = 1'b0;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_chan
        localparam int unsigned LSB = duty_lsb(g, CW);

        pwm_chan #(
            .CW       (CW),
            .MIN_DUTY (MIN_DUTY),
            .MAX_DUTY (MAX_DUTY)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_arm       (i_arm),
            .i_force_off (w_force_off),
            .i_wrap      (w_wrap),
            .i_cnt       (r_cnt),
            .i_duty      (i_duty_in[LSB +: CW]),
            .i_duty_we   (i_duty_we[g]),
            .o_pend      (w_pend[g]),
            .o_pwm       (o_pwm_out[g])
        );
    end

    assign o_period_tick = w_wrap;
    assign o_busy        = r_pend_p | (|w_pend);

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic [7:0]  period_in = '0;
    logic        period_we = 1'b0;
    logic [31:0] duty_in = '0;
    logic [3:0]  duty_we = '0;
    logic [3:0]  pwm_out;
    logic        tick;
    logic        busy;
    logic        wdog;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]     len;
        logic [3:0][7:0] hi;
    } exp_t;

    exp_t sb[$];

    pwm_multi #(
        .CH           (4),
        .CW           (8),
        .PERIOD_RST   (9),
        .MIN_DUTY     (2),
        .MAX_DUTY     (200),
        .WDOG_PERIODS (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_arm         (arm),
        .i_period_in   (period_in),
        .i_period_we   (period_we),
        .i_duty_in     (duty_in),
        .i_duty_we     (duty_we),
        .o_pwm_out     (pwm_out),
        .o_period_tick (tick),
        .o_busy        (busy),
        .o_wdog_fault  (wdog)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int len, input int h0, input int h1, input int h2, input int h3);
        exp_t e;
        e.len   = 32'(len);
        e.hi[0] = 8'(h0);
        e.hi[1] = 8'(h1);
        e.hi[2] = 8'(h2);
        e.hi[3] = 8'(h3);
        sb.push_back(e);
    endtask

    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (tick) found = 1'b1;
        end
        chk("tick_wait", 32'(found), 32'd1);
    endtask

    // Measures one whole period of output: the period starting at the wrap
    // just seen (at_tick=1) or at the next wrap. pwm lags cnt by one cycle,
    // so the window runs from the 2nd sample after the tick to one past the
    // next tick.
    task automatic measure(input bit at_tick, input string tag);
        exp_t e;
        int   len = 0;
        int   j = 0;
        int   hi[4];
        bit   done = 1'b0;
        foreach (hi[c]) hi[c] = 0;
        if (!at_tick) wait_tick();
        while (!done && j < 200) begin
            @(negedge clk);
            j++;
            if (j >= 2) begin
                for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
            end
            if (len != 0 && j == len + 1) done = 1'b1;
            else if (len == 0 && tick) len = j;
        end
        e = sb.pop_front();
        chk({tag, "_len"}, 32'(len), e.len);
        for (int c = 0; c < 4; c++)
            chk($sformatf("%s_hi%0d", tag, c), 32'(hi[c]), 32'(e.hi[c]));
    endtask

    task automatic wr_duty(input logic [3:0] mask, input logic [31:0] vals);
        @(negedge clk);
        for (int c = 0; c < 4; c++)
            if (mask[c]) duty_in[c*8 +: 8] = vals[c*8 +: 8];
        duty_we = mask;
        @(negedge clk);
        duty_we = '0;
    endtask

    task automatic wr_period(input logic [7:0] v);
        @(negedge clk);
        period_in = v;
        period_we = 1'b1;
        @(negedge clk);
        period_we = 1'b0;
    endtask

    initial begin
        int  n1;
        int  k;
        bit  seen;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm",  32'(pwm_out), 32'd0);
        chk("rst_tick", 32'(tick),    32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_wdog", 32'(wdog),    32'd0);
        rst_n = 1'b1;
        arm   = 1'b1;

`ifdef PWM_MULTI_WATCHDOG_EN
        wr_duty(4'b0001, 32'h0000_0003);
        wait_tick();
        wait_tick();
        chk("wd_early", 32'(wdog), 32'd0);
        wait_tick();
        @(negedge clk);
        chk("wd_fault", 32'(wdog), 32'd1);
        push_exp(10, 0, 0, 0, 0);
        measure(1'b0, "wd_off");
        wr_duty(4'b0010, 32'h0000_0500);
        chk("wd_clear", 32'(wdog),    32'd0);
        chk("wd_hold",  32'(pwm_out), 32'd0);
        push_exp(10, 3, 5, 2, 2);
        measure(1'b0, "wd_resume");
`else
        // Channel 0 duty 3; untouched channels clamp 0 up to 2 while armed.
        wr_duty(4'b0001, 32'h0000_0003);
        chk("busy_rise", 32'(busy), 32'd1);
        push_exp(10, 3, 2, 2, 2);
        measure(1'b0, "duty3");
        chk("busy_idle", 32'(busy), 32'd0);

        // Mid-period write on channel 1: no extra pulse in the current period.
        wait_tick();
        repeat (3) @(negedge clk);
        wr_duty(4'b0010, 32'h0000_0500);
        chk("busy_mid", 32'(busy), 32'd1);
        n1 = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (pwm_out[1]) n1++;
            if (tick) seen = 1'b1;
        end
        chk("no_runt",   32'(n1),   32'd0);
        chk("busy_hold", 32'(busy), 32'd1);
        push_exp(10, 3, 5, 2, 2);
        measure(1'b1, "duty5");
        chk("busy_fall", 32'(busy), 32'd0);

        // Clamp: ch2 1 -> 2, ch3 250 -> 200 (beyond the period: constant high).
        wr_duty(4'b1100, {8'd250, 8'd1, 8'd0, 8'd0});
        push_exp(10, 3, 5, 2, 10);
        measure(1'b0, "clamp");

        // Period 0 is stored as 1: 2-cycle period, every channel high throughout.
        wr_period(8'd0);
        push_exp(2, 2, 2, 2, 2);
        measure(1'b0, "per2");
        wr_period(8'd19);
        push_exp(20, 3, 5, 2, 20);
        measure(1'b0, "per20");

        // Period change mid-period must not shorten the running period.
        wait_tick();
        wr_period(8'd29);
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (tick) seen = 1'b1;
        end
        chk("per_hold", 32'(k), 32'd18);
        push_exp(30, 3, 5, 2, 30);
        measure(1'b1, "per30");

        // Arm drop and re-arm mid-pulse.
        wait_tick();
        @(negedge clk);
        @(negedge clk);
        chk("pre_disarm", 32'(pwm_out), 32'hF);
        arm = 1'b0;
        @(negedge clk);
        chk("disarm", 32'(pwm_out), 32'h0);
        arm = 1'b1;
        @(negedge clk);
        chk("rearm", 32'(pwm_out), 32'b1011);

        // Asynchronous reset mid-pulse.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_pwm",  32'(pwm_out), 32'd0);
        chk("rst_async_busy", 32'(busy),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(10, 2, 2, 2, 2);
        measure(1'b0, "post_rst");

        arm = 1'b0;
        push_exp(10, 0, 0, 0, 0);
        measure(1'b0, "disarmed");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
